// File: rtl/mux4_rr_arbiter_if.sv
// Handshake/data bundle between four requesters, the round-robin arbiter and its sink.
// Valid/ready: a beat transfers on a cycle where out_valid and out_ready are both high.
interface mux4_rr_arbiter_if #(
    parameter int DW = 8
);
    logic [3:0]    req;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] c;
    logic [DW-1:0] d;
    logic          out_ready;
    logic [1:0]    s;
    logic [DW-1:0] z;
    logic          out_valid;
    logic [3:0]    ack;
    logic          busy;

    modport master (
        output req, a, b, c, d, out_ready,
        input  s, z, out_valid, ack, busy
    );

    modport slave (
        input  req, a, b, c, d, out_ready,
        output s, z, out_valid, ack, busy
    );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Four-source round-robin arbiter/mux with an IDLE/GRANT FSM and a registered select.
// Define MUX4_ARB_BURST_EN to allow up to BURST_LEN back-to-back beats per grant.
module mux4_rr_arbiter #(
    parameter int DW        = 8,
    parameter int BURST_LEN = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    mux4_rr_arbiter_if.slave bus
);
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    if (BURST_LEN < 1 || BURST_LEN > 16) begin : g_bad_burst_len
        $error("BURST_LEN must be within 1..16");
    end

    state_e     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] s_q, s_d;
    logic [3:0] ack_q, ack_d;

`ifdef MUX4_ARB_BURST_EN
    logic [4:0] beat_q, beat_d;
`endif

    logic [1:0]    pick;
    logic          found;
    logic [1:0]    idx;
    logic          out_valid;
    logic          handshake;
    logic [DW-1:0] z_mux;

    // Rotating priority search starting at ptr_q.
    always_comb begin
        pick  = ptr_q;
        found = 1'b0;
        idx   = ptr_q;
        for (int i = 0; i < 4; i++) begin
            idx = ptr_q + i[1:0];
            if (!found && bus.req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    // Valid follows the live request so a withdrawn request kills the beat in the same cycle.
    assign out_valid = (state_q == GRANT) && bus.req[s_q];
    assign handshake = out_valid && bus.out_ready;

    always_comb begin
        z_mux = '0;
        case (s_q)
            2'd0:    z_mux = bus.a;
            2'd1:    z_mux = bus.b;
            2'd2:    z_mux = bus.c;
            default: z_mux = bus.d;
        endcase
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        s_d     = s_q;
        ack_d   = 4'b0000;
`ifdef MUX4_ARB_BURST_EN
        beat_d  = beat_q;
`endif
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    s_d     = pick;
                    state_d = GRANT;
`ifdef MUX4_ARB_BURST_EN
                    beat_d  = '0;
`endif
                end
            end
            GRANT: begin
                if (!bus.req[s_q]) begin
                    state_d = IDLE;
`ifdef MUX4_ARB_BURST_EN
                    // A burst that already moved data still hands priority on.
                    if (beat_q != '0) ptr_d = s_q + 2'd1;
                    beat_d = '0;
`endif
                end else if (handshake) begin
                    ack_d   = 4'(4'b0001 << s_q);
                    state_d = IDLE;
                    ptr_d   = s_q + 2'd1;
`ifdef MUX4_ARB_BURST_EN
                    if (int'(beat_q) + 1 < BURST_LEN) begin
                        state_d = GRANT;
                        ptr_d   = ptr_q;
                        beat_d  = beat_q + 5'd1;
                    end else begin
                        beat_d  = '0;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            s_q     <= 2'd0;
            ack_q   <= 4'b0000;
`ifdef MUX4_ARB_BURST_EN
            beat_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            s_q     <= s_d;
            ack_q   <= ack_d;
`ifdef MUX4_ARB_BURST_EN
            beat_q  <= beat_d;
`endif
        end
    end

    assign bus.s         = s_q;
    assign bus.z         = out_valid ? z_mux : '0;
    assign bus.out_valid = out_valid;
    assign bus.ack       = ack_q;
    assign bus.busy      = (state_q == GRANT);
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: cycle table plus reset, rotation and burst sequences.
module tb_mux4_rr_arbiter;
    localparam int DW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mux4_rr_arbiter_if #(.DW(DW)) bus ();

    mux4_rr_arbiter #(.DW(DW), .BURST_LEN(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [3:0] req;
        logic       rdy;
        logic [1:0] s;
        logic       v;
        logic [7:0] z;
        logic [3:0] ack;
        logic       busy;
    } vec_t;

    vec_t       vq[$];
    logic [7:0] dat[4];
    int         pass_cnt  = 0;
    int         total_cnt = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic check_out(input string tag, input logic [1:0] s, input logic v,
                             input logic [7:0] z, input logic [3:0] ack, input logic busy);
        check({tag, ".s"},         32'(bus.s),         32'(s));
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(v));
        check({tag, ".z"},         32'(bus.z),         32'(z));
        check({tag, ".ack"},       32'(bus.ack),       32'(ack));
        check({tag, ".busy"},      32'(bus.busy),      32'(busy));
    endtask

    // Inputs change on the falling edge; outputs are sampled 2 ns later, well before the rising edge.
    task automatic drive(input logic [3:0] r, input logic rdy);
        @(negedge clk);
        bus.req       = r;
        bus.out_ready = rdy;
        #2;
    endtask

    task automatic add(input logic [3:0] r, input logic rdy, input logic [1:0] s, input logic v,
                       input logic [7:0] z, input logic [3:0] ack, input logic busy);
        vec_t t;
        t.req = r; t.rdy = rdy; t.s = s; t.v = v; t.z = z; t.ack = ack; t.busy = busy;
        vq.push_back(t);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        dat[0] = 8'h00; dat[1] = 8'h0F; dat[2] = 8'hF0; dat[3] = 8'hFF;
        bus.a = dat[0]; bus.b = dat[1]; bus.c = dat[2]; bus.d = dat[3];
        bus.req       = 4'b0000;
        bus.out_ready = 1'b0;
        #1;
        check_out("in_reset", 2'd0, 1'b0, 8'h00, 4'b0000, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

`ifdef MUX4_ARB_BURST_EN
        drive(4'b0011, 1'b1);
        check_out("burst_idle", 2'd0, 1'b0, 8'h00, 4'b0000, 1'b0);
        for (int k = 0; k < 4; k++) begin
            drive(4'b0011, 1'b1);
            check_out($sformatf("burst_beat%0d", k), 2'd0, 1'b1, 8'h00,
                      (k == 0) ? 4'b0000 : 4'b0001, 1'b1);
        end
        drive(4'b0011, 1'b1);
        check_out("burst_bubble", 2'd0, 1'b0, 8'h00, 4'b0001, 1'b0);
        drive(4'b0011, 1'b1);
        check_out("burst_next_b", 2'd1, 1'b1, 8'h0F, 4'b0000, 1'b1);
`else
        //   req      rdy   s     v     z      ack      busy
        add(4'b0000, 1'b1, 2'd0, 1'b0, 8'h00, 4'b0000, 1'b0);
        add(4'b0001, 1'b1, 2'd0, 1'b0, 8'h00, 4'b0000, 1'b0);
        add(4'b0001, 1'b1, 2'd0, 1'b1, 8'h00, 4'b0000, 1'b1);
        add(4'b0000, 1'b1, 2'd0, 1'b0, 8'h00, 4'b0001, 1'b0);
        // b granted then withdrawn before any handshake: ptr must stay at b
        add(4'b0010, 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000, 1'b0);
        add(4'b0010, 1'b0, 2'd1, 1'b1, 8'h0F, 4'b0000, 1'b1);
        add(4'b0000, 1'b1, 2'd1, 1'b0, 8'h00, 4'b0000, 1'b1);
        add(4'b1111, 1'b1, 2'd1, 1'b0, 8'h00, 4'b0000, 1'b0);
        add(4'b1111, 1'b1, 2'd1, 1'b1, 8'h0F, 4'b0000, 1'b1);
        // all four requesting with ptr=c: order c, d, a
        add(4'b1111, 1'b1, 2'd1, 1'b0, 8'h00, 4'b0010, 1'b0);
        add(4'b1111, 1'b1, 2'd2, 1'b1, 8'hF0, 4'b0000, 1'b1);
        add(4'b1111, 1'b1, 2'd2, 1'b0, 8'h00, 4'b0100, 1'b0);
        add(4'b1111, 1'b1, 2'd3, 1'b1, 8'hFF, 4'b0000, 1'b1);
        add(4'b1111, 1'b1, 2'd3, 1'b0, 8'h00, 4'b1000, 1'b0);
        add(4'b1111, 1'b1, 2'd0, 1'b1, 8'h00, 4'b0000, 1'b1);
        add(4'b0000, 1'b1, 2'd0, 1'b0, 8'h00, 4'b0001, 1'b0);
        // c held with sink stalled for five cycles
        add(4'b0100, 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000, 1'b0);
        for (int i = 0; i < 5; i++) add(4'b0100, 1'b0, 2'd2, 1'b1, 8'hF0, 4'b0000, 1'b1);
        add(4'b0100, 1'b1, 2'd2, 1'b1, 8'hF0, 4'b0000, 1'b1);
        add(4'b0000, 1'b1, 2'd2, 1'b0, 8'h00, 4'b0100, 1'b0);
        add(4'b0000, 1'b1, 2'd2, 1'b0, 8'h00, 4'b0000, 1'b0);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].req, vq[i].rdy);
            check_out($sformatf("vec%0d", i), vq[i].s, vq[i].v, vq[i].z, vq[i].ack, vq[i].busy);
        end

        // ptr is now d, so a lone d request is granted; reset lands mid-grant
        drive(4'b1000, 1'b0);
        check_out("pre_d_idle", 2'd2, 1'b0, 8'h00, 4'b0000, 1'b0);
        drive(4'b1000, 1'b0);
        check_out("grant_d", 2'd3, 1'b1, 8'hFF, 4'b0000, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_out("rst_mid_grant", 2'd0, 1'b0, 8'h00, 4'b0000, 1'b0);
        @(negedge clk);
        rst_n         = 1'b1;
        bus.req       = 4'b1111;
        bus.out_ready = 1'b1;
        #2;
        check_out("post_rst_idle", 2'd0, 1'b0, 8'h00, 4'b0000, 1'b0);

        // full rotation from a after reset, one bubble between grants
        for (int k = 0; k < 5; k++) begin
            drive(4'b1111, 1'b1);
            check_out($sformatf("rot_grant%0d", k), 2'(k % 4), 1'b1, dat[k % 4], 4'b0000, 1'b1);
            drive(4'b1111, 1'b1);
            check_out($sformatf("rot_bubble%0d", k), 2'(k % 4), 1'b0, 8'h00,
                      4'(4'b0001 << (k % 4)), 1'b0);
        end
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/mux4_rr_arbiter.md
MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 The block SHALL have parameter DW, default 8, meaning data width of each requester and of z.
REQ-002 The block SHALL have parameter BURST_LEN, default 4, meaning max beats per grant in burst mode (1..16).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  4  request per source; bit0=a, bit1=b, bit2=c, bit3=d.
REQ-006 a, b, c, d  input  DW each  source data, stable while that source requests.
REQ-007 out_ready  input  1  sink accepts z this cycle.
REQ-008 s  output  2  registered select of the granted source (00=a, 01=b, 10=c, 11=d).
REQ-009 z  output  DW  selected data: a/b/c/d per s when out_valid=1, else all zeros.
REQ-010 out_valid  output  1  z holds a valid beat.
REQ-011 ack  output  4  one-hot, one-cycle pulse to the source whose beat completed.
REQ-012 busy  output  1  high in GRANT state.

Function
REQ-013 FSM SHALL have two states: IDLE, GRANT.
REQ-014 IDLE: if req!=0, pick first set bit searching ptr, ptr+1, ... mod 4; register s=pick; go GRANT; else stay.
REQ-015 Latency: req rising in cycle n -> out_valid=1 in cycle n+1.
REQ-016 GRANT: out_valid=1 while req[s]=1; handshake = out_valid & out_ready.
REQ-017 On handshake: ack[s]=1 next cycle, ptr = s+1 mod 4 (3 wraps to 0), return to IDLE (no-burst case).
REQ-018 Minimum one IDLE bubble between grants; back-to-back grants go to different sources when others request.
REQ-019 Granted source drops req before handshake: out_valid=0 same cycle, no ack, ptr unchanged, return to IDLE.
REQ-020 out_ready=0: s and z held; no ack; grant kept indefinitely.
REQ-021 Simultaneous req all four with ptr=2: grant order c, d, a, b.
REQ-022 ack SHALL never have more than one bit set; ack deasserted outside the cycle after a handshake.

Reset
REQ-023 rst_n=0 SHALL immediately force: state=IDLE, ptr=0, s=00, out_valid=0, z=0, ack=0000, busy=0, beat count=0.
REQ-024 Reset mid-GRANT SHALL abort the beat without ack; first grant after release starts search at a.

Configuration
REQ-025 Macro MUX4_ARB_BURST_EN defined: on handshake, if req[s] still 1 and beats<BURST_LEN, stay in GRANT with same s (no bubble, ack pulses each beat); on BURST_LEN-th beat or req[s]=0 go IDLE, ptr=s+1.
REQ-026 Macro MUX4_ARB_BURST_EN undefined: exactly one beat per grant per REQ-017; BURST_LEN ignored; no beat counter present.

Verification
REQ-027 a=00,b=0F,c=F0,d=FF, req=0001, out_ready=1 -> cycle+1: s=00, z=00000000, out_valid=1; next: ack=0001.
REQ-028 req=1111 held, out_ready=1, no burst -> s sequence 00,01,10,11,00 with one idle cycle between; z = 00,0F,F0,FF,00.
REQ-029 req=0100, out_ready=0 for 5 cycles -> s=10, z=F0 held, ack=0000; out_ready=1 -> ack=0100 next cycle.
REQ-030 Reset asserted during GRANT s=11 -> out_valid=0, s=00, z=0 immediately; after release req=1111 -> first s=00.
REQ-031 MUX4_ARB_BURST_EN, BURST_LEN=4, req=0011 held, out_ready=1 -> 4 consecutive beats s=00 (ack=0001 each), idle, then s=01.
REQ-032 req[1] dropped mid-grant with s=01 -> out_valid=0, ack=0000, next grant to another requester starts search at b.
